conv_window_buffer: RTL

CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

---
 rtl/conv_window_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/conv_window_buffer.sv
// Sliding-window line buffer for a KxK convolution over a raster pixel stream.
// Emits one window column per accepted pixel once K rows are buffered.
module conv_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 5,
  parameter int MAX_WIDTH  = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2:0]                   mode,
  input  logic                         stride,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic [KERNEL*DATA_WIDTH-1:0] out_col,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_win,
  output logic [4:0]                   out_x,
  output logic [4:0]                   out_y,
  output logic                         busy,
  output logic                         frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [4:0] KM1 = 5'(KERNEL - 1);

  state_t state_q, state_d;

  logic [4:0] w_q, x_q, y_q;
  logic [4:0] w_sel;
  logic       s2_q;
  logic       accept, restart, last_px, win_nxt;

  logic [DATA_WIDTH-1:0] lb [KERNEL-1][MAX_WIDTH];
  logic [KERNEL*DATA_WIDTH-1:0] col_nxt;

  always_comb begin
    case (mode)
      3'b001:  w_sel = 5'd24;
      3'b010:  w_sel = 5'd12;
      3'b011:  w_sel = 5'd8;
      3'b100:  w_sel = 5'd4;
      default: w_sel = 5'd28;
    endcase
  end

  assign in_ready   = (state_q == RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign restart    = start && ((state_q == IDLE) || (state_q == RUN));
  assign last_px    = (x_q == w_q - 5'd1) && (y_q == w_q - 5'd1);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  // Stride-2 phase test: (v-KM1) is even iff the low bits agree.
  assign win_nxt = (y_q >= KM1) && (x_q >= KM1) &&
                   (!s2_q || ((y_q[0] == KM1[0]) && (x_q[0] == KM1[0])));

  always_comb begin
    col_nxt = '0;
    for (int k = 0; k < KERNEL - 1; k++)
      col_nxt[k*DATA_WIDTH +: DATA_WIDTH] = lb[k][x_q];
    col_nxt[(KERNEL-1)*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (!start && accept && last_px) state_d = DRAIN;
      DRAIN: if (!out_valid || out_ready) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= 5'd28;
      s2_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
      out_win   <= 1'b0;
      out_col   <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (restart) begin
      w_q       <= w_sel;
      s2_q      <= stride;
      x_q       <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_col   <= col_nxt;
        out_x     <= x_q;
        out_y     <= y_q;
        out_win   <= win_nxt;
        out_valid <= (y_q >= KM1);
        if (x_q == w_q - 5'd1) begin
          x_q <= '0;
          y_q <= last_px ? 5'd0 : y_q + 5'd1;
        end else begin
          x_q <= x_q + 5'd1;
        end
      end
    end
  end

  // Line buffers shift up one row per column; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept && !start) begin
      for (int k = 0; k < KERNEL - 2; k++)
        lb[k][x_q] <= lb[k+1][x_q];
      lb[KERNEL-2][x_q] <= in_data;
    end
  end

endmodule
